// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 4-bit port arbiter.
package lcd_pkg;

  // Controller states; explicit encodings keep waveforms readable.
  typedef enum logic [3:0] {
    ST_PWR_WAIT    = 4'd0,
    ST_INIT_EN     = 4'd1,
    ST_INIT_GAP    = 4'd2,
    ST_INIT_SETTLE = 4'd3,
    ST_IDLE        = 4'd4,
    ST_HI_EN       = 4'd5,
    ST_HI_GAP      = 4'd6,
    ST_LO_EN       = 4'd7,
    ST_LO_GAP      = 4'd8,
    ST_SETTLE      = 4'd9
  } lcd_state_e;

  localparam int unsigned INIT_LEN   = 14;
  localparam int unsigned INIT_IDX_W = 4;

  // Power-on nibble stream: 4-bit wake-up, then 0x28, 0x0C, 0x06, 0x01, 0x80.
  // Entry 0 is the least-significant nibble.
  localparam logic [INIT_LEN-1:0][3:0] INIT_ROM = {
    4'h0, 4'h8, 4'h1, 4'h0, 4'h6, 4'h0, 4'hC,
    4'h0, 4'h8, 4'h2, 4'h2, 4'h3, 4'h3, 4'h3
  };

  // Init nibbles followed by the long settle (first wake-up, low half of clear).
  localparam logic [INIT_IDX_W-1:0] INIT_LONG_IDX_A = 4'd0;
  localparam logic [INIT_IDX_W-1:0] INIT_LONG_IDX_B = 4'd11;
  localparam logic [INIT_IDX_W-1:0] INIT_LAST_IDX   = 4'(INIT_LEN - 1);

  localparam logic [7:0] CMD_CLEAR     = 8'h01;
  localparam logic [7:0] CMD_HOME      = 8'h02;
  localparam logic [7:0] CMD_SET_DDRAM = 8'h80;

  // Clear and home need the long execution time; everything else is short.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] b);
    return !rs && ((b == CMD_CLEAR) || (b == CMD_HOME));
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, pointer advanced on accept.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_valid,
  input  logic       enable,
  output logic [1:0] grant_c,
  output logic       grant_idx_c
);

  // ptr_q names the requester preferred when both are valid.
  logic ptr_q;

  // One-hot grant; a lone requester always wins, a tie goes to the pointer.
  always_comb begin
    grant_c     = 2'b00;
    grant_idx_c = 1'b0;
    if (enable) begin
      case (req_valid)
        2'b01: begin
          grant_c     = 2'b01;
          grant_idx_c = 1'b0;
        end
        2'b10: begin
          grant_c     = 2'b10;
          grant_idx_c = 1'b1;
        end
        2'b11: begin
          grant_c     = ptr_q ? 2'b10 : 2'b01;
          grant_idx_c = ptr_q;
        end
        default: begin
          grant_c     = 2'b00;
          grant_idx_c = 1'b0;
        end
      endcase
    end
  end

  // After serving a requester, prefer the other one next time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else if (|grant_c) begin
      ptr_q <= ~grant_idx_c;
    end
  end

endmodule

// File: rtl/lcd_bus_arbiter.sv
// HD44780 4-bit port owner: power-on init, then round-robin byte writes
// from two requesters, each serialised as two EN-strobed nibbles.
module lcd_bus_arbiter
  import lcd_pkg::*;
#(
  parameter int unsigned EN_CYCLES      = 800,
  parameter int unsigned GAP_CYCLES     = 800,
  parameter int unsigned CMD_CYCLES     = 2000,
  parameter int unsigned LONG_CYCLES    = 60000,
  parameter int unsigned POWERUP_CYCLES = 12000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  input  logic [1:0]  req_rs,
  input  logic [15:0] req_data,
  output logic [1:0]  req_ready,
  output logic        grant_id,
  output logic        busy,
  output logic        init_done,
  output logic        lcd_rs,
  output logic        lcd_en,
  output logic [3:0]  lcd_data
);

  localparam int unsigned MAX_A   = (EN_CYCLES > GAP_CYCLES) ? EN_CYCLES : GAP_CYCLES;
  localparam int unsigned MAX_B   = (CMD_CYCLES > LONG_CYCLES) ? CMD_CYCLES : LONG_CYCLES;
  localparam int unsigned MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_MAX = (MAX_C > POWERUP_CYCLES) ? MAX_C : POWERUP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

  lcd_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       limit_c;
  logic                   last_c;
  logic [INIT_IDX_W-1:0]  idx_q, idx_d;
  logic [INIT_IDX_W-1:0]  idx_nxt_c;
  logic [3:0]             lo_nib_q, lo_nib_d;
  logic                   long_q, long_d;
  logic                   grant_id_q, grant_id_d;
  logic                   init_done_q, init_done_d;
  logic                   lcd_rs_q, lcd_rs_d;
  logic                   lcd_en_q, lcd_en_d;
  logic [3:0]             lcd_data_q, lcd_data_d;
  logic                   busy_q, busy_d;

  logic [1:0]             grant_c;
  logic                   grant_idx_c;
  logic                   sel_rs_c;
  logic [7:0]             sel_byte_c;

  rr_arb2 u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .enable      (state_q == ST_IDLE),
    .grant_c     (grant_c),
    .grant_idx_c (grant_idx_c)
  );

  assign sel_rs_c   = req_rs[grant_idx_c];
  assign sel_byte_c = grant_idx_c ? req_data[15:8] : req_data[7:0];
  assign idx_nxt_c  = idx_q + INIT_IDX_W'(1);

  // Final count value of the current state; each state lasts limit+1 cycles.
  always_comb begin
    limit_c = '0;
    case (state_q)
      ST_PWR_WAIT: limit_c = CNT_W'(POWERUP_CYCLES - 1);
      ST_INIT_EN, ST_HI_EN, ST_LO_EN: limit_c = CNT_W'(EN_CYCLES - 1);
      ST_INIT_GAP, ST_HI_GAP, ST_LO_GAP: limit_c = CNT_W'(GAP_CYCLES - 1);
      ST_INIT_SETTLE: begin
        if ((idx_q == INIT_LONG_IDX_A) || (idx_q == INIT_LONG_IDX_B)) begin
          limit_c = CNT_W'(LONG_CYCLES - 1);
        end else begin
          limit_c = CNT_W'(CMD_CYCLES - 1);
        end
      end
      ST_SETTLE: limit_c = long_q ? CNT_W'(LONG_CYCLES - 1) : CNT_W'(CMD_CYCLES - 1);
      default:   limit_c = '0;
    endcase
  end

  assign last_c = (cnt_q == limit_c);

  // Next-state and next-output logic; pins only change when entering an EN state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = last_c ? '0 : cnt_q + CNT_W'(1);
    idx_d       = idx_q;
    lo_nib_d    = lo_nib_q;
    long_d      = long_q;
    grant_id_d  = grant_id_q;
    init_done_d = init_done_q;
    lcd_rs_d    = lcd_rs_q;
    lcd_data_d  = lcd_data_q;

    case (state_q)
      ST_PWR_WAIT: begin
        if (last_c) begin
          state_d    = ST_INIT_EN;
          idx_d      = '0;
          lcd_rs_d   = 1'b0;
          lcd_data_d = INIT_ROM[0];
        end
      end
      ST_INIT_EN: if (last_c) state_d = ST_INIT_GAP;
      ST_INIT_GAP: if (last_c) state_d = ST_INIT_SETTLE;
      ST_INIT_SETTLE: begin
        if (last_c) begin
          if (idx_q == INIT_LAST_IDX) begin
            state_d     = ST_IDLE;
            init_done_d = 1'b1;
          end else begin
            state_d    = ST_INIT_EN;
            idx_d      = idx_nxt_c;
            lcd_rs_d   = 1'b0;
            lcd_data_d = INIT_ROM[idx_nxt_c];
          end
        end
      end
      ST_IDLE: begin
        cnt_d = '0;
        if (|grant_c) begin
          state_d    = ST_HI_EN;
          grant_id_d = grant_idx_c;
          lcd_rs_d   = sel_rs_c;
          lcd_data_d = sel_byte_c[7:4];
          lo_nib_d   = sel_byte_c[3:0];
          long_d     = is_long_cmd(sel_rs_c, sel_byte_c);
        end
      end
      ST_HI_EN: if (last_c) state_d = ST_HI_GAP;
      ST_HI_GAP: begin
        if (last_c) begin
          state_d    = ST_LO_EN;
          lcd_data_d = lo_nib_q;
        end
      end
      ST_LO_EN: if (last_c) state_d = ST_LO_GAP;
      ST_LO_GAP: if (last_c) state_d = ST_SETTLE;
      ST_SETTLE: if (last_c) state_d = ST_IDLE;
      default: begin
        state_d = ST_PWR_WAIT;
        cnt_d   = '0;
      end
    endcase

    lcd_en_d = (state_d == ST_INIT_EN) || (state_d == ST_HI_EN) || (state_d == ST_LO_EN);
    busy_d   = (state_d != ST_IDLE);
  end

  // State, counter and registered pin drivers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_PWR_WAIT;
      cnt_q       <= '0;
      idx_q       <= '0;
      lo_nib_q    <= '0;
      long_q      <= 1'b0;
      grant_id_q  <= 1'b0;
      init_done_q <= 1'b0;
      lcd_rs_q    <= 1'b0;
      lcd_en_q    <= 1'b0;
      lcd_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      lo_nib_q    <= lo_nib_d;
      long_q      <= long_d;
      grant_id_q  <= grant_id_d;
      init_done_q <= init_done_d;
      lcd_rs_q    <= lcd_rs_d;
      lcd_en_q    <= lcd_en_d;
      lcd_data_q  <= lcd_data_d;
      busy_q      <= busy_d;
    end
  end

  assign req_ready = grant_c;
  assign grant_id  = grant_id_q;
  assign busy      = busy_q;
  assign init_done = init_done_q;
  assign lcd_rs    = lcd_rs_q;
  assign lcd_en    = lcd_en_q;
  assign lcd_data  = lcd_data_q;

endmodule

// File: doc/lcd_bus_arbiter.md
Name: lcd_bus_arbiter

Overview:
Owns the shared HD44780 LCD port, which runs in 4-bit mode with RS, EN and D[7:4]. After power-up it runs the fixed init sequence itself. It then grants the port round-robin between two byte-level requesters, for example the countdown-timer display writer and the clock display writer. Each accepted byte is serialised as two EN-strobed nibbles, with command-dependent settle time, so requesters never touch LCD timing.

Parameters:
EN_CYCLES, 800, cycles lcd_en held high per nibble
GAP_CYCLES, 800, cycles lcd_en held low after each nibble
CMD_CYCLES, 2000, settle cycles after an ordinary byte (or init nibble)
LONG_CYCLES, 60000, settle cycles after clear (0x01), home (0x02), and the first init nibble
POWERUP_CYCLES, 12000000, idle wait after reset before first init nibble

Ports:
clk  in  1  system clock (Sys_Clk0)
rst_n  in  1  asynchronous active-low reset
req_valid  in  2  per-requester byte valid; bit i = requester i
req_rs  in  2  per-requester RS for the byte (0 command, 1 data)
req_data  in  16  per-requester byte; [7:0] requester 0, [15:8] requester 1
req_ready  out  2  one-hot acceptance strobe; transfer when valid&ready
grant_id  out  1  requester whose byte is currently in flight
busy  out  1  high whenever not in IDLE
init_done  out  1  high once init sequence completed; sticky until reset
lcd_rs  out  1  LCD register select
lcd_en  out  1  LCD enable strobe
lcd_data  out  4  LCD D[7:4]

Behaviour:
- Reset is asynchronous. On rst_n low, all outputs go to 0 immediately: lcd_en=0, lcd_rs=0, lcd_data=0, req_ready=0, busy=0, init_done=0, grant_id=0. State goes to PWR_WAIT, counters clear, and the rr pointer is set to prefer requester 0.
- Reset mid-transfer aborts the nibble. No partial acceptance is reported.
- States: PWR_WAIT, INIT_EN, INIT_GAP, INIT_SETTLE, IDLE, HI_EN, HI_GAP, LO_EN, LO_GAP, SETTLE.
- PWR_WAIT: count POWERUP_CYCLES, then go to INIT_EN with rom index 0.
- Init ROM holds 14 nibbles, all with rs=0: 3,3,3,2,2,8,0,C,0,6,0,1,8,0. This is the 4-bit wake-up, then 0x28, 0x0C, 0x06, 0x01, 0x80.
- Init nibble timing: INIT_EN holds lcd_en=1 for EN_CYCLES, INIT_GAP holds lcd_en=0 for GAP_CYCLES, then INIT_SETTLE. lcd_data and lcd_rs are stable for the whole nibble window.
- INIT_SETTLE lasts LONG_CYCLES after index 0 and after index 11 (the low nibble of 0x01); otherwise CMD_CYCLES. After index 13, set init_done=1 and go to IDLE.
- IDLE, arbitration: req_ready is combinational in IDLE only.
  - One valid requester: it is granted.
  - Both valid: grant the requester not served last.
  - Exactly one req_ready bit is high that cycle.
  - Capture rs/data, set grant_id, flip the pointer to the other requester, and go to HI_EN next cycle. lcd_en rises 1 cycle after acceptance.
- Requesters hold valid, rs and data until ready. Dropping valid before ready is legal, and nothing is sent.
- Byte send:
  - HI_EN for EN_CYCLES with data[7:4], then HI_GAP for GAP_CYCLES.
  - LO_EN and LO_GAP likewise with data[3:0].
  - SETTLE lasts LONG_CYCLES if rs=0 and data is 0x01 or 0x02; otherwise CMD_CYCLES.
  - Then return to IDLE.
  - Total per byte: 2*(EN+GAP)+settle cycles after the acceptance cycle.
- req_ready stays 0 in every state other than IDLE, including before init_done. Requests during init wait.
- Back-to-back: if valid is held continuously, the next acceptance occurs on the first IDLE cycle. Two continuously valid requesters strictly alternate.
- lcd_rs and lcd_data change only on the cycle entering an *_EN state. They are never changed while lcd_en=1 or on its falling edge.
- Counter: one down/up counter sized $clog2 of the largest parameter + 1. Each wait is exact: N cycles in-state.

Decomposition:
- Shared package lcd_pkg holds:
  - state enum
  - init ROM constant array (14 x 4 bits) and its length
  - CMD_CLEAR=8'h01, CMD_HOME=8'h02, CMD_SET_DDRAM=8'h80
- One sub-module, rr_arb2: combinational 2-way round-robin grant from req_valid and pointer, plus pointer register updated on accept.

Test Plan:
(All scenarios use EN=4, GAP=4, CMD=10, LONG=50, POWERUP=100.)
- Reset release, no requests -> lcd_en first rises at cycle 100. 14 init pulses occur with lcd_rs=0 and data sequence 3,3,3,2,2,8,0,C,0,6,0,1,8,0. Gap after pulse 1 and pulse 12 is 50. init_done rises after the last settle, and req_ready stays 0 throughout.
- After init, requester 0 sends rs=1, data 0x35 -> req_ready[0] pulses 1 cycle. Pulses show lcd_rs=1, lcd_data 3 then 5, each en high for 4 cycles. busy is high for 26 cycles.
- Both requesters valid continuously (0x41 and 0x42) -> grants alternate 0,1,0,1. The LCD shows 4,1,4,2,4,1,4,2, and exactly one req_ready bit is high per acceptance.
- Requester 1 sends rs=0, 0x01 -> settle is 50 cycles. The same with 0x28 -> settle is 10 cycles.
- rst_n asserted during LO_EN of a byte -> lcd_en=0 within the same cycle (async). After release, full PWR_WAIT and init rerun, and init_done=0 until done.
- Requester 0 drops valid while the arbiter is busy with requester 1 -> no acceptance for requester 0. The arbiter returns to IDLE with busy=0.
